seq_detector_param: RTL

Parametrised, runtime-programmable serial sequence detector. It generalises the fixed Mealy 1100 overlap detector to any pattern of 1..MAX_LEN bits, with selectable overlap/non-overlap mode, an input-valid qualifier, and a saturating match counter. It sits between a serial bit source and downstream event logic, and exposes ps/ns for debug and waveform visibility, as the earlier detector did.

---
 rtl/seq_det_pkg.sv | 32 +++
 rtl/seq_match_core.sv | 55 +++++
 rtl/seq_detector_param.sv | 97 +++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants, types and pattern-compare helpers for the serial sequence detector.
// Pattern positions are counted in arrival order: position 0 is bit [len-1] of the pattern.
package seq_det_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int MAX_LEN_CAP = 16;
    localparam int LW_DEF      = $clog2(MAX_LEN_DEF + 1);

    typedef logic [LW_DEF-1:0]      len_t;
    typedef logic [MAX_LEN_DEF-1:0] pat_t;
    typedef logic [MAX_LEN_CAP-1:0] pat_cap_t;

    function automatic logic pat_bit(pat_cap_t pat, int len, int pos);
        pat_cap_t t;
        t = pat >> (len - 1 - pos);
        return t[0];
    endfunction

    // True when the k-bit pattern segment starting at arrival position a equals
    // the k-bit segment starting at position b.
    function automatic logic prefix_suffix_eq(pat_cap_t pat, int len, int a, int b, int k);
        logic eq;
        eq = 1'b1;
        for (int i = 0; i < MAX_LEN_CAP; i++) begin
            if (i < k && pat_bit(pat, len, a + i) != pat_bit(pat, len, b + i)) begin
                eq = 1'b0;
            end
        end
        return eq;
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Combinational prefix-automaton step: given the matched-prefix length and the new bit,
// returns the next prefix length and whether the full pattern just completed.
module seq_match_core import seq_det_pkg::*; #(
    parameter  int MAX_LEN = MAX_LEN_DEF,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LW-1:0]      len_i,
    input  logic [LW-1:0]      ps_i,
    input  logic               in_i,
    input  logic               overlap_i,
    output logic [LW-1:0]      ns_raw_o,
    output logic               hit_o
);

    pat_cap_t pat_ext;
    int       len_v;
    int       ps_v;
    int       border_len;
    int       k_best;

    always_comb begin
        pat_ext                = '0;
        pat_ext[MAX_LEN-1:0]   = pattern_i;
        len_v                  = int'(len_i);
        ps_v                   = int'(ps_i);
        border_len             = 0;
        k_best                 = 0;

        // Longest proper border: suffix of length b equals prefix of length b.
        for (int b = 1; b < MAX_LEN; b++) begin
            if (b < len_v && prefix_suffix_eq(pat_ext, len_v, len_v - b, 0, b)) begin
                border_len = b;
            end
        end

        // Candidate is prefix(ps) followed by in; keep the longest suffix that is a prefix.
        for (int k = 1; k <= MAX_LEN; k++) begin
            if (k <= ps_v + 1 && k <= len_v &&
                pat_bit(pat_ext, len_v, k - 1) == in_i &&
                prefix_suffix_eq(pat_ext, len_v, ps_v + 1 - k, 0, k - 1)) begin
                k_best = k;
            end
        end

        hit_o = (len_v != 0) && (k_best == len_v);

        if (hit_o) begin
            ns_raw_o = overlap_i ? LW'(border_len) : '0;
        end else begin
            ns_raw_o = LW'(k_best);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable Mealy sequence detector with overlap select, input qualifier
// and saturating match counter. ps/ns are exported for debug visibility.
//
//   ps        | meaning
//   0         | no pattern bits matched (also held while len == 0)
//   k (1..L-1)| last k accepted bits equal the first k pattern bits
module seq_detector_param import seq_det_pkg::*; #(
    parameter  int                 MAX_LEN     = MAX_LEN_DEF,
    parameter  int                 CNT_W       = 8,
    parameter  logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_1100),
    parameter  int                 RST_LEN     = 4,
    parameter  logic               RST_OVERLAP = 1'b1,
    localparam int                 LW          = $clog2(MAX_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               cfg_load_i,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [LW-1:0]      cfg_len_i,
    input  logic               cfg_overlap_i,
    input  logic               in_valid_i,
    input  logic               in_i,
    output logic               q_o,
    output logic [LW-1:0]      ps_o,
    output logic [LW-1:0]      ns_o,
    output logic [CNT_W-1:0]   match_count_o
);

    localparam logic [LW-1:0] RST_LEN_C = (RST_LEN > MAX_LEN) ? LW'(MAX_LEN) : LW'(RST_LEN);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LW-1:0]      len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [LW-1:0]      ps_q, ps_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]      ns_raw;
    logic               hit;
    logic               q_int;

    seq_match_core #(
        .MAX_LEN (MAX_LEN)
    ) u_core (
        .pattern_i (pattern_q),
        .len_i     (len_q),
        .ps_i      (ps_q),
        .in_i      (in_i),
        .overlap_i (overlap_q),
        .ns_raw_o  (ns_raw),
        .hit_o     (hit)
    );

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        ps_d      = ps_q;
        cnt_d     = cnt_q;
        q_int     = 1'b0;

        if (cfg_load_i) begin
            pattern_d = cfg_pattern_i;
            len_d     = (cfg_len_i > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len_i;
            overlap_d = cfg_overlap_i;
            ps_d      = '0;
            cnt_d     = '0;
        end else if (in_valid_i) begin
            ps_d  = ns_raw;
            q_int = hit;
            if (hit && cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pattern_q <= RST_PATTERN;
            len_q     <= RST_LEN_C;
            overlap_q <= RST_OVERLAP;
            ps_q      <= '0;
            cnt_q     <= '0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            ps_q      <= ps_d;
            cnt_q     <= cnt_d;
        end
    end

    // Reset gates the combinational outputs so nothing leaks out while it is held.
    assign q_o           = q_int & ~reset_i;
    assign ns_o          = reset_i ? '0 : ps_d;
    assign ps_o          = ps_q;
    assign match_count_o = cnt_q;

endmodule
